// File: rtl/soc_io_if.sv
// Core data-bus and data-memory side signals shared by the core, soc_io and dmem.
// Pure wiring: no latency, no backpressure.
interface soc_io_if;
  logic        we;
  logic [3:0]  byteEnable;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        dmem_we;
  logic [31:0] dmem_rd;

  modport master (
    output we, byteEnable, a, wd, dmem_rd,
    input  rd, dmem_we
  );

  modport slave (
    input  we, byteEnable, a, wd, dmem_rd,
    output rd, dmem_we
  );
endinterface

// File: rtl/soc_io.sv
// Memory-mapped I/O block: LED, free-running cycle counter and compare timer with irq.
// Reads are combinational, writes land on the next rising edge; never stalls the core.
module soc_io #(
  parameter logic [31:0] IO_BASE   = 32'hFFFF_0000,
  parameter int          LED_W     = 4,
  parameter logic [31:0] RESET_LED = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  soc_io_if.slave          bus,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  typedef struct packed {
    logic irqen;
    logic match;
    logic reload;
    logic en;
  } ctrl_t;

  localparam logic [5:0] OFF_LED  = 6'h00;
  localparam logic [5:0] OFF_CYC  = 6'h01;
  localparam logic [5:0] OFF_CMP  = 6'h02;
  localparam logic [5:0] OFF_CNT  = 6'h03;
  localparam logic [5:0] OFF_CTRL = 6'h04;

  logic [LED_W-1:0] led_q;
  logic [31:0]      cycle_q;
  logic [31:0]      cmp_q;
  logic [31:0]      cnt_q, cnt_n;
  ctrl_t            ctrl_q, ctrl_n;

  logic       io_sel;
  logic [5:0] off;
  logic       wr_io;
  logic       match_evt;
  logic       unused_addr;

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

  assign io_sel      = (bus.a[31:8] == IO_BASE[31:8]);
  assign off         = bus.a[7:2];
  assign wr_io       = bus.we & io_sel;
  assign bus.dmem_we = bus.we & ~io_sel;
  assign unused_addr = ^bus.a[1:0];

  assign match_evt = ctrl_q.en && (cnt_q == cmp_q);

  // Hardware timer update first, then software bytes override on top of it.
  always_comb begin
    ctrl_n = ctrl_q;
    cnt_n  = cnt_q;
    if (match_evt) begin
      ctrl_n.match = 1'b1;
      if (ctrl_q.reload) cnt_n = 32'h0;
      else               ctrl_n.en = 1'b0;
    end else if (ctrl_q.en) begin
      cnt_n = cnt_q + 32'h1;
    end
    if (wr_io && off == OFF_CTRL && bus.byteEnable[0]) begin
      ctrl_n.en     = bus.wd[0];
      ctrl_n.reload = bus.wd[1];
      ctrl_n.irqen  = bus.wd[3];
      if (bus.wd[2] && !match_evt) ctrl_n.match = 1'b0;
    end
    if (wr_io && off == OFF_CNT)
      cnt_n = merge(cnt_n, bus.wd, bus.byteEnable);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q   <= RESET_LED[LED_W-1:0];
      cycle_q <= 32'h0;
      cmp_q   <= 32'h0;
      cnt_q   <= 32'h0;
      ctrl_q  <= '0;
    end else begin
      cycle_q <= cycle_q + 32'h1;
      cnt_q   <= cnt_n;
      ctrl_q  <= ctrl_n;
      if (wr_io && off == OFF_LED)
        led_q <= LED_W'(merge(32'(led_q), bus.wd, bus.byteEnable));
      if (wr_io && off == OFF_CMP)
        cmp_q <= merge(cmp_q, bus.wd, bus.byteEnable);
    end
  end

  always_comb begin
    bus.rd = bus.dmem_rd;
    if (io_sel) begin
      case (off)
        OFF_LED:  bus.rd = 32'(led_q);
        OFF_CYC:  bus.rd = cycle_q;
        OFF_CMP:  bus.rd = cmp_q;
        OFF_CNT:  bus.rd = cnt_q;
        OFF_CTRL: bus.rd = {28'h0, ctrl_q};
        default:  bus.rd = 32'h0;
      endcase
    end
  end

  assign led = led_q;
  assign irq = ctrl_q.match & ctrl_q.irqen;

endmodule

// File: tb/tb_soc_io.sv
// Directed bench for soc_io: register map, store routing, timer match/reload and reset.
module tb_soc_io;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [31:0] R_LED = BASE + 32'h00;
  localparam logic [31:0] R_CYC = BASE + 32'h04;
  localparam logic [31:0] R_CMP = BASE + 32'h08;
  localparam logic [31:0] R_CNT = BASE + 32'h0C;
  localparam logic [31:0] R_CTL = BASE + 32'h10;

  logic       clk;
  logic       reset;
  logic [3:0] led;
  logic       irq;
  logic [31:0] v;
  int checks = 0;
  int errors = 0;

  soc_io_if bus ();

  soc_io #(.IO_BASE(BASE), .LED_W(4), .RESET_LED(32'h5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .led   (led),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic io_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus.we = 1'b1;
    bus.a = addr;
    bus.wd = data;
    bus.byteEnable = be;
    tick();
    bus.we = 1'b0;
    bus.byteEnable = 4'h0;
  endtask

  task automatic io_rd(input logic [31:0] addr, output logic [31:0] data);
    bus.we = 1'b0;
    bus.a = addr;
    #1;
    data = bus.rd;
  endtask

  initial begin
    reset = 1'b1;
    bus.we = 1'b0;
    bus.byteEnable = 4'h0;
    bus.a = 32'h0;
    bus.wd = 32'h0;
    bus.dmem_rd = 32'hDEAD_BEEF;
    tick();
    tick();
    chk("rst_led", 32'(led), 32'h5);
    chk("rst_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    io_rd(R_CYC, v); chk("cyc_first", v, 32'h0);
    io_rd(R_CTL, v); chk("rst_ctrl", v, 32'h0);
    io_rd(R_CNT, v); chk("rst_cnt", v, 32'h0);
    io_rd(R_CMP, v); chk("rst_cmp", v, 32'h0);
    tick();
    io_rd(R_CYC, v); chk("cyc_second", v, 32'h1);

    // LED store through the I/O window
    bus.we = 1'b1; bus.a = R_LED; bus.wd = 32'hA; bus.byteEnable = 4'hF;
    #1;
    chk("io_dmem_we", 32'(bus.dmem_we), 32'h0);
    tick();
    bus.we = 1'b0; bus.byteEnable = 4'h0;
    chk("led_out", 32'(led), 32'hA);
    io_rd(R_LED, v); chk("led_rd", v, 32'hA);
    io_rd(BASE + 32'h3, v); chk("led_rd_unaligned", v, 32'hA);
    io_wr(R_LED, 32'hFFFF_FFF5, 4'hF);
    io_rd(R_LED, v); chk("led_upper_drop", v, 32'h5);
    io_wr(R_LED, 32'h0000_000C, 4'h0);
    chk("led_be0_noop", 32'(led), 32'h5);

    // plain memory store and read-through
    bus.we = 1'b1; bus.a = 32'h10; bus.wd = 32'h1234; bus.byteEnable = 4'hF;
    #1;
    chk("mem_dmem_we", 32'(bus.dmem_we), 32'h1);
    chk("mem_rd", bus.rd, 32'hDEAD_BEEF);
    tick();
    bus.we = 1'b0; bus.byteEnable = 4'h0;

    io_wr(BASE + 32'h14, 32'hFFFF_FFFF, 4'hF);
    io_rd(BASE + 32'h14, v); chk("unmapped_rd", v, 32'h0);

    // byte-lane store into CMP
    io_wr(R_CMP, 32'h1122_3344, 4'hF);
    io_wr(R_CMP, 32'h0000_5500, 4'b0010);
    io_rd(R_CMP, v); chk("cmp_byte", v, 32'h1122_5544);

    // auto-reload with irq
    io_wr(R_CMP, 32'h3, 4'hF);
    io_wr(R_CTL, 32'hB, 4'hF);
    io_rd(R_CNT, v); chk("rl_cnt0", v, 32'h0);
    tick(); io_rd(R_CNT, v); chk("rl_cnt1", v, 32'h1);
    tick(); io_rd(R_CNT, v); chk("rl_cnt2", v, 32'h2);
    tick(); io_rd(R_CNT, v); chk("rl_cnt3", v, 32'h3);
    chk("rl_irq_pre", 32'(irq), 32'h0);
    tick(); io_rd(R_CNT, v); chk("rl_cnt_wrap", v, 32'h0);
    chk("rl_irq", 32'(irq), 32'h1);
    io_rd(R_CTL, v); chk("rl_ctrl_match", v, 32'hF);
    io_wr(R_CTL, 32'hF, 4'hF);
    chk("w1c_irq", 32'(irq), 32'h0);
    io_rd(R_CTL, v); chk("w1c_ctrl", v, 32'hB);
    io_rd(R_CNT, v); chk("w1c_cnt", v, 32'h1);
    tick(); tick();
    io_wr(R_CTL, 32'hF, 4'hF);
    io_rd(R_CTL, v); chk("set_wins", v, 32'hF);
    io_rd(R_CNT, v); chk("set_wins_cnt", v, 32'h0);
    io_wr(R_CTL, 32'h4, 4'hF);
    io_rd(R_CTL, v); chk("stop_ctrl", v, 32'h0);
    chk("stop_irq", 32'(irq), 32'h0);

    // software CNT write merged with increment
    io_wr(R_CMP, 32'hFFFF_FFF0, 4'hF);
    io_wr(R_CNT, 32'h10, 4'hF);
    io_rd(R_CNT, v); chk("cnt_wr", v, 32'h10);
    io_wr(R_CTL, 32'h1, 4'hF);
    io_wr(R_CNT, 32'h0000_AB00, 4'b0010);
    io_rd(R_CNT, v); chk("cnt_merge", v, 32'h0000_AB11);
    tick();
    io_rd(R_CNT, v); chk("cnt_inc", v, 32'h0000_AB12);
    io_wr(R_CTL, 32'h0, 4'hF);
    tick();
    io_rd(R_CNT, v); chk("cnt_hold", v, 32'h0000_AB13);

    // one-shot
    io_wr(R_CNT, 32'h0, 4'hF);
    io_wr(R_CMP, 32'h2, 4'hF);
    io_wr(R_CTL, 32'h1, 4'hF);
    tick(); tick(); tick(); tick();
    io_rd(R_CTL, v); chk("os_ctrl", v, 32'h4);
    io_rd(R_CNT, v); chk("os_cnt", v, 32'h2);
    chk("os_irq", 32'(irq), 32'h0);
    io_wr(R_CTL, 32'h8, 4'b0001);
    chk("irqen_irq", 32'(irq), 32'h1);
    io_wr(R_CTL, 32'h4, 4'hF);
    io_rd(R_CTL, v); chk("os_clear", v, 32'h0);
    io_wr(R_CTL, 32'h1, 4'hF);
    io_wr(R_CTL, 32'h1, 4'hF);
    io_rd(R_CTL, v); chk("sw_en_wins", v, 32'h5);
    tick();
    io_rd(R_CTL, v); chk("os_again", v, 32'h4);

    // reset while running
    io_wr(R_LED, 32'hF, 4'hF);
    io_wr(R_CMP, 32'd100, 4'hF);
    io_wr(R_CTL, 32'hB, 4'hF);
    chk("pre_rst_led", 32'(led), 32'hF);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_led", 32'(led), 32'h5);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    io_rd(R_CNT, v); chk("mid_rst_cnt", v, 32'h0);
    io_rd(R_CTL, v); chk("mid_rst_ctrl", v, 32'h0);
    io_rd(R_CYC, v); chk("mid_rst_cyc0", v, 32'h0);
    tick();
    io_rd(R_CYC, v); chk("mid_rst_cyc1", v, 32'h1);
    tick();
    io_rd(R_CYC, v); chk("mid_rst_cyc2", v, 32'h2);
    io_wr(R_CYC, 32'h0, 4'hF);
    io_rd(R_CYC, v); chk("cyc_ro", v, 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/soc_io.md
SOC_IO -- requirements
Module: soc_io

Interface
REQ-001 Parameter IO_BASE, default 32'hFFFF_0000; base of 256-byte I/O window (address bits [31:8] match IO_BASE[31:8]).
REQ-002 Parameter LED_W, default 4, range 1..32; LED register width.
REQ-003 Parameter RESET_LED, default 0; LED value after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 we  input  1  core store strobe (MemWriteM).
REQ-007 byteEnable  input  4  per-byte store enables; bit i covers wd[8i+7:8i].
REQ-008 a  input  32  core data address (ALUResultM); word-aligned, a[1:0] ignored.
REQ-009 wd  input  32  core store data (WriteDataM).
REQ-010 rd  output  32  read data returned to core (RD_data).
REQ-011 dmem_we  output  1  store strobe forwarded to data memory.
REQ-012 dmem_rd  input  32  data memory read data.
REQ-013 led  output  LED_W  LED register contents.
REQ-014 irq  output  1  timer interrupt request.

Function
REQ-015 io_sel = (a[31:8] == IO_BASE[31:8]); dmem_we = we & ~io_sel, combinational.
REQ-016 rd combinational: io_sel ? selected I/O register : dmem_rd.
REQ-017 Register map (offset a[7:2]): 0x00 LED RW; 0x04 CYCLE RO; 0x08 CMP RW; 0x0C CNT RW; 0x10 CTRL RW/W1C.
REQ-018 Unmapped offsets read 32'h0; writes to them, and to CYCLE, have no effect.
REQ-019 I/O writes occur on rising edge when we & io_sel; only bytes with byteEnable set are updated; byteEnable = 0 is a no-op.
REQ-020 LED: holds LED_W bits; bits above LED_W-1 read 0, discarded on write; led = LED register.
REQ-021 CYCLE: 32-bit, increments by 1 every cycle after reset, wraps 32'hFFFF_FFFF -> 0.
REQ-022 CTRL bits: [0] EN RW, [1] RELOAD RW, [2] MATCH W1C (set by hardware), [3] IRQEN RW; [31:4] read 0.
REQ-023 CNT increments by 1 each cycle while EN = 1, wraps at 32 bits; holds while EN = 0.
REQ-024 Match event: EN = 1 and CNT == CMP in a cycle; next edge sets MATCH; if RELOAD = 1 CNT <= 0 and EN stays 1, else CNT holds at CMP and EN <= 0 (one-shot).
REQ-025 Software write to CNT in the same cycle as increment or match reload: written bytes take software value, unwritten bytes take hardware-updated value.
REQ-026 MATCH set and W1C of MATCH in same cycle: set wins, MATCH = 1.
REQ-027 Software write setting EN in a match cycle: software value of EN wins.
REQ-028 irq = MATCH & IRQEN, combinational from registers; stays high until MATCH cleared or IRQEN cleared.
REQ-029 Stores never reach both targets: an I/O-window store leaves dmem untouched.

Reset
REQ-030 On reset: LED = RESET_LED[LED_W-1:0], CYCLE = 0, CMP = 0, CNT = 0, CTRL = 0; hence led = RESET_LED, irq = 0.
REQ-031 Reset takes priority over any concurrent write or timer event; CYCLE reads 0 in the first cycle after reset deasserts, 1 in the next.
REQ-032 Reset asserted mid-count: timer stops, MATCH cleared, no match event produced that cycle.

Verification
REQ-033 Store 32'h0000_000A, byteEnable 4'b1111, to IO_BASE+0x00 (LED_W=4) -> led = 4'hA, dmem_we = 0; read returns 32'h0000_000A.
REQ-034 Store to 32'h0000_0010, we = 1 -> dmem_we = 1; read of same address returns dmem_rd unchanged.
REQ-035 CMP = 3, CTRL = 4'b1011 -> CNT 0,1,2,3,0,...; MATCH = 1 and irq = 1 one edge after CNT = 3; W1C write 32'h4 to CTRL drops irq next cycle.
REQ-036 CMP = 2, CTRL = 4'b0001 (one-shot) -> CNT stops at 2, EN reads 0, MATCH = 1, irq = 0 (IRQEN = 0).
REQ-037 Byte store 32'h0000_5500, byteEnable 4'b0010, to CMP holding 32'h1122_3344 -> CMP = 32'h1122_5544.
REQ-038 Assert reset with EN = 1, LED = 4'hF -> next cycle led = RESET_LED, CNT = 0, CTRL = 0, irq = 0; CYCLE restarts 0,1,2.
